// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master, single-outstanding memory arbiter.
//   Master 0 (MMU) and master 1 (DMA loader) each hand over a one-cycle
//   request pulse that is held in a private capture slot until it has been
//   served. One transaction at a time goes downstream; its completion is
//   routed back to the master that was granted.
//
// Ports
//   clk, rstn                     clock, synchronous active-low reset
//   mX_request_enable             request pulse from master X (X = 0, 1)
//   mX_req_mode/addr/wdata/wstrb  request fields (mode 0 = read, 1 = write)
//   mX_response_enable            one-cycle completion pulse to master X
//   mX_resp_data                  read data to master X (held between pulses)
//   request_enable, req_*         downstream request (single-cycle pulse,
//                                 fields held until the response arrives)
//   response_enable, resp_data    downstream completion
//
// Build option
//   MEM_ARBITER_ROUND_ROBIN_EN    defined: contention goes to the master that
//                                 was not granted last; undefined: master 0
//                                 always wins contention.
module mem_arbiter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_request_enable,
    input  logic        m0_req_mode,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    input  logic [3:0]  m0_req_wstrb,
    input  logic        m1_request_enable,
    input  logic        m1_req_mode,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    input  logic [3:0]  m1_req_wstrb,
    output logic        m0_response_enable,
    output logic [31:0] m0_resp_data,
    output logic        m1_response_enable,
    output logic [31:0] m1_resp_data,
    output logic        request_enable,
    output logic        req_mode,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        response_enable,
    input  logic [31:0] resp_data
);

    typedef enum logic [1:0] {IDLE, WAIT_RESP, DONE} state_t;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // The grant register doubles as last_grant; resetting it to 1 makes
    // master 0 win the first contention.
    localparam logic GNT_RST = 1'b1;
`else
    localparam logic GNT_RST = 1'b0;
`endif

    // Master-indexed views of the request inputs
    logic [1:0]       in_en, in_mode;
    logic [1:0][31:0] in_addr, in_wdata;
    logic [1:0][3:0]  in_wstrb;

    assign in_en    = {m1_request_enable, m0_request_enable};
    assign in_mode  = {m1_req_mode,       m0_req_mode};
    assign in_addr  = {m1_req_addr,       m0_req_addr};
    assign in_wdata = {m1_req_wdata,      m0_req_wdata};
    assign in_wstrb = {m1_req_wstrb,      m0_req_wstrb};

    state_t           state_q, state_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       slot_mode_q, slot_mode_d;
    logic [1:0][31:0] slot_addr_q, slot_addr_d;
    logic [1:0][31:0] slot_wdata_q, slot_wdata_d;
    logic [1:0][3:0]  slot_wstrb_q, slot_wstrb_d;
    logic             gnt_q, gnt_d;
    logic             req_en_q, req_en_d;
    logic             req_mode_q, req_mode_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      req_wdata_q, req_wdata_d;
    logic [3:0]       req_wstrb_q, req_wstrb_d;
    logic [1:0]       rsp_en_q, rsp_en_d;
    logic [1:0][31:0] rsp_data_q, rsp_data_d;
    logic             win;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        slot_mode_d  = slot_mode_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        slot_wstrb_d = slot_wstrb_q;
        gnt_d        = gnt_q;
        req_en_d     = 1'b0;
        req_mode_d   = req_mode_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_wstrb_d  = req_wstrb_q;
        rsp_en_d     = 2'b00;
        rsp_data_d   = rsp_data_q;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        win = (&pend_q) ? ~gnt_q : pend_q[1];
`else
        win = ~pend_q[0];
`endif

        // Capture runs in every state; a busy slot ignores new pulses.
        // Capture and the completion clear below never touch the same slot
        // in one cycle, since capture needs the slot to be free.
        for (int m = 0; m < 2; m++) begin
            if (in_en[m] && !pend_q[m]) begin
                pend_d[m]       = 1'b1;
                slot_mode_d[m]  = in_mode[m];
                slot_addr_d[m]  = in_addr[m];
                slot_wdata_d[m] = in_wdata[m];
                slot_wstrb_d[m] = in_wstrb[m];
            end
        end

        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    gnt_d       = win;
                    req_en_d    = 1'b1;
                    req_mode_d  = slot_mode_q[win];
                    req_addr_d  = slot_addr_q[win];
                    req_wdata_d = slot_wdata_q[win];
                    req_wstrb_d = slot_wstrb_q[win];
                    state_d     = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (response_enable) begin
                    rsp_en_d[gnt_q]   = 1'b1;
                    rsp_data_d[gnt_q] = resp_data;
                    pend_d[gnt_q]     = 1'b0;
                    state_d           = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            pend_q       <= 2'b00;
            slot_mode_q  <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            slot_wstrb_q <= '0;
            gnt_q        <= GNT_RST;
            req_en_q     <= 1'b0;
            req_mode_q   <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
            rsp_en_q     <= 2'b00;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            slot_mode_q  <= slot_mode_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            slot_wstrb_q <= slot_wstrb_d;
            gnt_q        <= gnt_d;
            req_en_q     <= req_en_d;
            req_mode_q   <= req_mode_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_wstrb_q  <= req_wstrb_d;
            rsp_en_q     <= rsp_en_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign request_enable     = req_en_q;
    assign req_mode           = req_mode_q;
    assign req_addr           = req_addr_q;
    assign req_wdata          = req_wdata_q;
    assign req_wstrb          = req_wstrb_q;
    assign m0_response_enable = rsp_en_q[0];
    assign m1_response_enable = rsp_en_q[1];
    assign m0_resp_data       = rsp_data_q[0];
    assign m1_resp_data       = rsp_data_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level reference model (pending set,
// slot contents, last grant, one outstanding transaction) plus a downstream
// memory responder feed per-master expected-response queues; a separate
// monitor pops them whenever a master sees a completion pulse.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_request_enable, m0_req_mode;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic [3:0]  m0_req_wstrb;
    logic        m1_request_enable, m1_req_mode;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic [3:0]  m1_req_wstrb;
    logic        m0_response_enable, m1_response_enable;
    logic [31:0] m0_resp_data, m1_resp_data;
    logic        request_enable, req_mode;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        response_enable;
    logic [31:0] resp_data;

    // Downstream responder: automatic (model) or manual (directed tests)
    logic        auto_resp_q = 1'b0;
    logic [31:0] auto_data   = '0;
    logic        man_resp;
    logic [31:0] man_data;
    assign response_enable = auto_resp_q | man_resp;
    assign resp_data       = auto_resp_q ? auto_data : man_data;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .m0_request_enable(m0_request_enable), .m0_req_mode(m0_req_mode),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
        .m1_request_enable(m1_request_enable), .m1_req_mode(m1_req_mode),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
        .m0_response_enable(m0_response_enable), .m0_resp_data(m0_resp_data),
        .m1_response_enable(m1_response_enable), .m1_resp_data(m1_resp_data),
        .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .response_enable(response_enable), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {logic mode; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} req_t;
    typedef struct {logic [31:0] data; int cyc;} rsp_t;

    // Reference model state
    bit          pend[2];
    req_t        slot[2];
    bit          outst;
    int          g;
    bit          last = 1'b1;
    int          idle_cnt;
    int          auto_cnt;
    bit          auto_en = 1'b0;
    rsp_t        q0[$], q1[$];
    logic [31:0] hist[$];

    // Model: at each negedge, account for what the previous posedge sampled.
    always @(negedge clk) begin : model
        bit   po[2];
        bit   oo;
        int   w;
        bit   inen[2];
        req_t inr[2];
        inen[0] = m0_request_enable;
        inen[1] = m1_request_enable;
        inr[0]  = '{m0_req_mode, m0_req_addr, m0_req_wdata, m0_req_wstrb};
        inr[1]  = '{m1_req_mode, m1_req_addr, m1_req_wdata, m1_req_wstrb};
        auto_resp_q = 1'b0;
        if (!rstn) begin
            chk("rst_req_en",   32'(request_enable), 32'd0);
            chk("rst_rsp_en",   32'({m1_response_enable, m0_response_enable}), 32'd0);
            chk("rst_m0_data",  m0_resp_data, 32'd0);
            chk("rst_m1_data",  m1_resp_data, 32'd0);
            chk("rst_req_addr", req_addr, 32'd0);
            chk("rst_req_wdat", req_wdata, 32'd0);
            chk("rst_req_ctl",  32'({req_mode, req_wstrb}), 32'd0);
            pend = '{1'b0, 1'b0};
            outst = 1'b0; last = 1'b1; idle_cnt = 0; auto_cnt = 0;
            q0.delete(); q1.delete();
        end else begin
            po = pend;
            oo = outst;
            if (request_enable) begin
                chk("issue_allowed", 32'({oo, po[0] | po[1]}), 32'd1);
                if (!oo && (po[0] || po[1])) begin
                    if (po[0] && po[1]) w = RR ? int'(!last) : 0;
                    else                w = po[1] ? 1 : 0;
                    chk("issue_addr",  req_addr,  slot[w].addr);
                    chk("issue_wdata", req_wdata, slot[w].wdata);
                    chk("issue_ctl",   32'({req_mode, req_wstrb}), 32'({slot[w].mode, slot[w].wstrb}));
                    outst = 1'b1; g = w; last = w[0]; idle_cnt = 0;
                    hist.push_back(req_addr);
                    auto_cnt = int'($urandom_range(0, 3));
                end
            end else if (!oo && (po[0] || po[1])) begin
                idle_cnt++;
                chk("issue_latency", 32'(idle_cnt > 1), 32'd0);
            end
            if (oo) chk("req_stable", req_addr, slot[g].addr);
            for (int m = 0; m < 2; m++)
                if (inen[m] && !po[m]) begin pend[m] = 1'b1; slot[m] = inr[m]; end
            if (oo && response_enable) begin
                pend[g] = 1'b0;
                if (g == 0) q0.push_back('{resp_data, cyc});
                else        q1.push_back('{resp_data, cyc});
                outst = 1'b0;
            end
            if (auto_en && outst) begin
                if (auto_cnt == 0) begin auto_resp_q = 1'b1; auto_data = $urandom; end
                else auto_cnt--;
            end
        end
    end

    // Monitor: pops an expected completion whenever a master sees a pulse.
    logic [31:0] last0 = '0, last1 = '0;
    always @(negedge clk) begin : monitor
        rsp_t e;
        #1;
        if (!rstn) begin
            last0 = '0; last1 = '0;
        end else begin
            if (m0_response_enable) begin
                if (q0.size() == 0) chk("m0_unexpected_rsp", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("m0_rsp_data", m0_resp_data, e.data);
                    chk("m0_rsp_cycle", 32'(cyc), 32'(e.cyc));
                    last0 = e.data;
                end
            end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
                chk("m0_missing_rsp", 32'd1, 32'd0);
                void'(q0.pop_front());
            end
            if (m1_response_enable) begin
                if (q1.size() == 0) chk("m1_unexpected_rsp", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("m1_rsp_data", m1_resp_data, e.data);
                    chk("m1_rsp_cycle", 32'(cyc), 32'(e.cyc));
                    last1 = e.data;
                end
            end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
                chk("m1_missing_rsp", 32'd1, 32'd0);
                void'(q1.pop_front());
            end
            chk("m0_data_hold", m0_resp_data, last0);
            chk("m1_data_hold", m1_resp_data, last1);
        end
    end

    // Inputs change 2 time units after each negedge
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic idle_masters();
        m0_request_enable = 0; m0_req_mode = 0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_wstrb = '0;
        m1_request_enable = 0; m1_req_mode = 0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_wstrb = '0;
    endtask

    task automatic drive(input int m, input logic md, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin m0_request_enable = 1; m0_req_mode = md; m0_req_addr = a; m0_req_wdata = d; m0_req_wstrb = s; end
        else        begin m1_request_enable = 1; m1_req_mode = md; m1_req_addr = a; m1_req_wdata = d; m1_req_wstrb = s; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend[0] || pend[1] || outst || q0.size() != 0 || q1.size() != 0) && n < 100) begin
            step(); n++;
        end
        chk("drain_timeout", 32'(n >= 100), 32'd0);
        repeat (3) step();
    endtask

    task automatic do_reset();
        rstn = 0;
        repeat (2) step();
        rstn = 1;
    endtask

    initial begin
        rstn = 0; man_resp = 0; man_data = '0;
        idle_masters();
        repeat (3) step();
        rstn = 1;

        // Single read: latency, field pass-through, routed completion
        step();
        drive(0, 1'b0, 32'h8000_1000, 32'h0, 4'h0);
        step(); idle_masters();
        chk("lat_edge_n", 32'(request_enable), 32'd0);
        step();
        chk("lat_edge_n1", 32'(request_enable), 32'd1);
        chk("lat_addr", req_addr, 32'h8000_1000);
        chk("lat_mode", 32'(req_mode), 32'd0);
        step();
        chk("lat_edge_n2", 32'(request_enable), 32'd0);
        man_resp = 1; man_data = 32'hDEAD_BEEF;
        step(); man_resp = 0;
        chk("rd_m0_pulse", 32'(m0_response_enable), 32'd1);
        chk("rd_m0_data", m0_resp_data, 32'hDEAD_BEEF);
        chk("rd_m1_quiet", 32'(m1_response_enable), 32'd0);
        step();
        chk("rd_pulse_end", 32'(m0_response_enable), 32'd0);
        chk("rd_data_held", m0_resp_data, 32'hDEAD_BEEF);
        drain();

        // Simultaneous requests: m0 first, m1 afterwards unchanged
        hist.delete(); auto_en = 1;
        step();
        drive(0, 1'b0, 32'h100, 32'h0, 4'h0);
        drive(1, 1'b1, 32'h200, 32'h1234_5678, 4'hF);
        step(); idle_masters();
        drain();
        chk("both_count", 32'(hist.size()), 32'd2);
        if (hist.size() == 2) begin
            chk("both_first", hist[0], 32'h100);
            chk("both_second", hist[1], 32'h200);
        end

        // Repeated m1 pulse while pending is dropped
        hist.delete(); auto_en = 0;
        step(); drive(1, 1'b0, 32'h300, 32'h0, 4'h3);
        step(); drive(1, 1'b0, 32'h400, 32'h0, 4'h3);
        step(); idle_masters(); man_resp = 1; man_data = 32'h0BAD_F00D;
        step(); man_resp = 0;
        repeat (4) step();
        chk("dup_count", 32'(hist.size()), 32'd1);
        if (hist.size() == 1) chk("dup_addr", hist[0], 32'h300);
        drain();

        // Reset during WAIT_RESP, late response afterwards
        step(); drive(0, 1'b0, 32'h500, 32'h0, 4'h0);
        step(); idle_masters();
        step(); chk("rst_mid_issue", 32'(request_enable), 32'd1);
        rstn = 0;
        step(); rstn = 1;
        step(); man_resp = 1; man_data = 32'h5555_AAAA;
        step(); man_resp = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("late_rsp_quiet", 32'({request_enable, m1_response_enable, m0_response_enable}), 32'd0);
        end

        // Stray response while idle
        step(); man_resp = 1; man_data = 32'h1111_2222;
        step(); man_resp = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_rsp_quiet", 32'({request_enable, m1_response_enable, m0_response_enable}), 32'd0);
        end

        // Both masters saturating: alternation or fixed priority
        do_reset();
        hist.delete(); auto_en = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            drive(0, 1'b0, 32'h0000_1000 + 32'(i), 32'(i), 4'h1);
            drive(1, 1'b1, 32'h8000_2000 + 32'(i), 32'(i), 4'h2);
        end
        step(); idle_masters();
        drain();
        chk("sat_enough", 32'(hist.size() >= 4), 32'd1);
        if (hist.size() >= 4)
            for (int i = 0; i < 4; i++)
                chk("sat_grant_order", 32'(hist[i][31]), RR ? 32'(i % 2) : 32'd0);

        // Randomized traffic, including pulses while pending
        for (int i = 0; i < 400; i++) begin
            step(); idle_masters();
            for (int m = 0; m < 2; m++)
                if ($urandom_range(0, 3) == 0)
                    drive(m, 1'($urandom), $urandom, $urandom, 4'($urandom));
        end
        step(); idle_masters();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; all widths fixed (addr/data 32, wstrb 4, mode 1: 0=read, 1=write).
REQ-002 SHALL have port: clk  in  1  sole clock, all logic on posedge.
REQ-003 SHALL have port: rstn  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 SHALL have ports m0_request_enable/m1_request_enable  in  1  one-cycle request pulse from master 0 (MMU) / master 1 (DMA loader).
REQ-005 SHALL have ports mX_req_mode  in  1, mX_req_addr  in  32, mX_req_wdata  in  32, mX_req_wstrb  in  4 (X=0,1)  request fields, valid with mX_request_enable.
REQ-006 SHALL have ports mX_response_enable  out  1  one-cycle completion pulse; mX_resp_data  out  32  read data (X=0,1).
REQ-007 SHALL have ports request_enable  out  1, req_mode  out  1, req_addr  out  32, req_wdata  out  32, req_wstrb  out  4  downstream memory request.
REQ-008 SHALL have ports response_enable  in  1, resp_data  in  32  downstream completion.

Function
REQ-009 SHALL hold one capture slot per master (mode, addr, wdata, wstrb, pending bit).
REQ-010 On posedge with mX_request_enable=1 and pending_X=0, SHALL latch mX fields into slot X and set pending_X.
REQ-011 SHALL ignore mX_request_enable while pending_X=1 (slot contents unchanged).
REQ-012 SHALL implement states IDLE, WAIT_RESP, DONE; reset state IDLE.
REQ-013 IDLE, no pending bit set: SHALL stay IDLE with request_enable=0.
REQ-014 IDLE, any pending bit set: SHALL select winner per REQ-022/023, record grant, copy winner slot onto req_* fields, drive request_enable=1, move to WAIT_RESP.
REQ-015 request_enable SHALL be a single-cycle pulse: cleared on the first posedge in WAIT_RESP.
REQ-016 Latency: master pulse sampled at edge N, arbiter idle, no contention -> request_enable high from edge N+1 to edge N+2.
REQ-017 req_* fields SHALL stay stable from issue until the transaction leaves WAIT_RESP.
REQ-018 WAIT_RESP with response_enable=1: SHALL drive granted mX_response_enable=1, mX_resp_data=resp_data, clear pending_X, move to DONE.
REQ-019 DONE: SHALL clear mX_response_enable and return to IDLE; mX_resp_data holds its last value.
REQ-020 response_enable outside WAIT_RESP SHALL be ignored.
REQ-021 Non-granted master's slot and pending bit SHALL be unaffected by the granted transaction; a request captured during WAIT_RESP/DONE is served from the next IDLE.
REQ-022 With both pending in IDLE, winner per Configuration; single pending master always wins.
REQ-023 Fields SHALL pass through unmodified; no address decoding or width conversion.

Reset
REQ-024 rstn=0 SHALL force: state IDLE, both pending bits 0, last_grant=1, request_enable=0, m0/m1_response_enable=0, m0/m1_resp_data=0, req_mode=0, req_addr=0, req_wdata=0, req_wstrb=0.
REQ-025 Reset mid-transaction SHALL drop it silently; a late response_enable after reset SHALL be ignored (IDLE).
REQ-026 Request pulses coinciding with rstn=0 SHALL be discarded.

Configuration
REQ-027 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: on contention, winner is the master not in last_grant; last_grant updated at each issue; each master waits at most one other transaction.
REQ-028 MEM_ARBITER_ROUND_ROBIN_EN undefined: on contention master 0 always wins; last_grant register not implemented; reset values otherwise identical.

Verification
REQ-029 Reset, m0 read pulse addr=0x80001000 at edge N -> request_enable high N+1..N+2, req_addr=0x80001000, req_mode=0; response_enable with resp_data=0xDEADBEEF -> m0_response_enable one-cycle pulse, m0_resp_data=0xDEADBEEF, m1_response_enable stays 0.
REQ-030 m0 and m1 pulse same edge (m0 read 0x100, m1 write 0x200 wdata=0x12345678 wstrb=0xF) -> m0 served first; m1 issued in next IDLE with unchanged fields; both response pulses occur once each.
REQ-031 Round-robin build, both masters re-request immediately after each completion for 4 transactions -> grants alternate m0,m1,m0,m1; fixed-priority build -> m0 wins every contention.
REQ-032 m1 pulses twice while pending (addr 0x300 then 0x400) -> one downstream request only, req_addr=0x300.
REQ-033 rstn=0 during WAIT_RESP, then response_enable=1 after release -> no mX_response_enable pulse, pending bits 0, request_enable stays 0.
REQ-034 response_enable=1 while IDLE with no pending -> no state change, no response pulses.
